// File: rtl/stopwatch_run_ctrl.sv
// rtl/stopwatch_run_ctrl.sv - run/pause/clear/lap controller with gated tick prescaler
module stopwatch_run_ctrl #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned TICK_HZ = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_run_stop,
  input  logic       i_clear,
  input  logic       i_lap,
  output logic       o_tick,
  output logic       o_clear,
  output logic       o_running,
  output logic       o_lap_hold,
  output logic [1:0] o_state
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned CW  = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_LAP   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic          clear_q, clear_d;
  logic          running;

  assign running = (state_q == S_RUN) || (state_q == S_LAP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      clear_q <= clear_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    clear_d = 1'b0;

    // Prescaler follows the pre-edge state, so a pause on the terminal count still ticks.
    if (running) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (i_run_stop) begin
          state_d = S_RUN;
        end else if (i_clear) begin
          cnt_d   = '0;
          clear_d = 1'b1;
        end
      end
      S_RUN: begin
        if (i_run_stop) begin
          state_d = S_PAUSE;
        end else if (i_lap) begin
          state_d = S_LAP;
        end
      end
      S_LAP: begin
        if (i_run_stop) begin
          state_d = S_PAUSE;
        end else if (i_lap) begin
          state_d = S_RUN;
        end
      end
      S_PAUSE: begin
        if (i_run_stop) begin
          state_d = S_RUN;
        end else if (i_clear) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          clear_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_tick     = tick_q;
  assign o_clear    = clear_q;
  assign o_running  = running;
  assign o_lap_hold = (state_q == S_LAP);
  assign o_state    = state_q;

endmodule

// File: tb/tb_stopwatch_run_ctrl.sv
// tb/tb_stopwatch_run_ctrl.sv - scoreboard bench for stopwatch_run_ctrl
module tb_stopwatch_run_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_run_stop, i_clear, i_lap;
  logic       o_tick, o_clear, o_running, o_lap_hold;
  logic [1:0] o_state;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int tick_exp[$];
  int clear_exp[$];
  int e0, r, c, e1, l, m, n, e2;

  stopwatch_run_ctrl #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_run_stop (i_run_stop),
    .i_clear    (i_clear),
    .i_lap      (i_lap),
    .o_tick     (o_tick),
    .o_clear    (o_clear),
    .o_running  (o_running),
    .o_lap_hold (o_lap_hold),
    .o_state    (o_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic pulse(input logic rs, input logic cl, input logic lp);
    i_run_stop = rs;
    i_clear    = cl;
    i_lap      = lp;
    cycle();
    i_run_stop = 1'b0;
    i_clear    = 1'b0;
    i_lap      = 1'b0;
  endtask

  task automatic idle_until(input int t);
    while (cyc < t) cycle();
  endtask

  task automatic chk_outs(input string tag, input int st, input int run, input int lap);
    chk({tag, "_state"}, int'(o_state), st);
    chk({tag, "_running"}, int'(o_running), run);
    chk({tag, "_lap_hold"}, int'(o_lap_hold), lap);
  endtask

  // Scoreboard: every tick/clear pulse must match the next expected edge number.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (o_tick === 1'b1) begin
        if (tick_exp.size() == 0) chk("tick_unexpected", cyc, -1);
        else chk("tick_edge", cyc, tick_exp.pop_front());
      end
      if (o_clear === 1'b1) begin
        if (clear_exp.size() == 0) chk("clear_unexpected", cyc, -1);
        else chk("clear_edge", cyc, clear_exp.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b0;
    i_run_stop = 1'b0;
    i_clear = 1'b0;
    i_lap = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_outs("reset", 0, 0, 0);
    chk("reset_tick", int'(o_tick), 0);
    chk("reset_clear", int'(o_clear), 0);
    @(negedge clk);
    rst = 1'b1;

    repeat (50) cycle();
    chk_outs("idle50", 0, 0, 0);
    chk("idle50_tick", int'(o_tick), 0);

    pulse(1, 0, 0);
    e0 = cyc;
    chk_outs("run", 1, 1, 0);
    tick_exp.push_back(e0 + 10);
    tick_exp.push_back(e0 + 20);
    tick_exp.push_back(e0 + 30);
    idle_until(e0 + 33);

    // Count is 3 before this edge, so 4 is held in PAUSE.
    pulse(1, 0, 0);
    chk_outs("pause", 2, 0, 0);
    repeat (30) cycle();
    pulse(1, 0, 0);
    r = cyc;
    chk_outs("resume", 1, 1, 0);
    tick_exp.push_back(r + 6);
    idle_until(r + 6);

    pulse(1, 0, 0);
    chk_outs("pause2", 2, 0, 0);
    pulse(0, 1, 0);
    c = cyc;
    clear_exp.push_back(c);
    chk_outs("clear", 0, 0, 0);
    chk("clear_pulse", int'(o_clear), 1);
    cycle();
    chk("clear_width", int'(o_clear), 0);

    pulse(1, 0, 0);
    e1 = cyc;
    tick_exp.push_back(e1 + 10);
    idle_until(e1 + 10);

    pulse(0, 0, 1);
    l = cyc;
    chk_outs("lap", 3, 1, 1);
    tick_exp.push_back(l + 9);
    tick_exp.push_back(l + 19);
    idle_until(l + 19);
    pulse(0, 0, 1);
    chk_outs("lap_release", 1, 1, 0);
    tick_exp.push_back(l + 29);
    idle_until(l + 29);

    pulse(1, 1, 1);
    m = cyc;
    chk_outs("all3", 2, 0, 0);
    chk("all3_clear", int'(o_clear), 0);
    repeat (5) cycle();

    pulse(1, 0, 0);
    n = cyc;
    idle_until(n + 6);
    rst = 1'b0;
    #1;
    chk_outs("midrst", 0, 0, 0);
    chk("midrst_tick", int'(o_tick), 0);
    chk("midrst_clear", int'(o_clear), 0);
    @(negedge clk);
    rst = 1'b1;

    pulse(1, 0, 0);
    e2 = cyc;
    tick_exp.push_back(e2 + 10);
    idle_until(e2 + 12);

    chk("tick_queue_drained", tick_exp.size(), 0);
    chk("clear_queue_drained", clear_exp.size(), 0);
    chk("final_state", int'(o_state), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    n_err++;
    $display("FAIL timeout observed=%0d expected=finish", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "timeout");
  end

endmodule
